alu_secuenciador: RTL

Issue-side sequencer for the 7-bit shift+ALU datapath. Accepts operation requests over a valid/ready handshake and drives registered `A`, `B` and `ALUControl` into the ALU. It captures `Resultado`, `CarryOut`, `Overflow` and `Cero` one cycle later and returns them over a valid/ready response channel. It also supports accumulator chaining, where the previous result feeds the next `A`. It sits between a command source (testbench or controller FSM) and the combinational ALU, and is agnostic to ALU op encoding.

---
 rtl/alu_secuenciador.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_secuenciador.sv
// Issue-side sequencer for the 7-bit shift+ALU datapath.
// Takes requests over valid/ready, drives registered A/B/ALUControl into the
// combinational ALU, captures the ALU result one cycle later and returns it
// over a valid/ready response channel. Supports accumulator chaining.
// Optional feature macro: ALU_SEQ_STICKY_EN (sticky CarryOut/Overflow flags
// with flags_clr). When undefined the sticky outputs are tied low.
module alu_secuenciador #(
  parameter int OP_W  = 7,
  parameter int RES_W = OP_W + 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_A,
  input  logic [OP_W-1:0]  req_B,
  input  logic [3:0]       req_Control,
  input  logic             req_chain,
  output logic [OP_W-1:0]  A,
  output logic [OP_W-1:0]  B,
  output logic [3:0]       ALUControl,
  input  logic [RES_W-1:0] Resultado,
  input  logic             CarryOut,
  input  logic             Overflow,
  input  logic             Cero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_Resultado,
  output logic [2:0]       rsp_flags,
  output logic             sticky_CarryOut,
  output logic             sticky_Overflow,
  input  logic             flags_clr,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  // Only the low OP_W bits of the previous result are ever reused as A, so the
  // carry bit of Resultado is dropped at the point of storage.
  logic [OP_W-1:0] last_Resultado;

  // Ready is a pure decode of the state register.
  assign req_ready = (state == IDLE);

  // Sequencer FSM: accept, let the ALU settle one cycle, then hold the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      A              <= '0;
      B              <= '0;
      ALUControl     <= '0;
      rsp_valid      <= 1'b0;
      rsp_Resultado  <= '0;
      rsp_flags      <= '0;
      op_count       <= '0;
      last_Resultado <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            A          <= req_chain ? last_Resultado : req_A;
            B          <= req_B;
            ALUControl <= req_Control;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_Resultado <= Resultado;
          rsp_flags     <= {CarryOut, Overflow, Cero};
          rsp_valid     <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            op_count       <= op_count + CNT_W'(1);
            last_Resultado <= rsp_Resultado[OP_W-1:0];
            rsp_valid      <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_EN
  // Sticky flags: a capture that sees the flag set takes priority over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_CarryOut <= 1'b0;
      sticky_Overflow <= 1'b0;
    end else begin
      if ((state == EXEC) && CarryOut) begin
        sticky_CarryOut <= 1'b1;
      end else if (flags_clr) begin
        sticky_CarryOut <= 1'b0;
      end
      if ((state == EXEC) && Overflow) begin
        sticky_Overflow <= 1'b1;
      end else if (flags_clr) begin
        sticky_Overflow <= 1'b0;
      end
    end
  end
`else
  // Sticky flags compiled out; the clear input has no effect.
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
  assign sticky_CarryOut  = 1'b0;
  assign sticky_Overflow  = 1'b0;
`endif

endmodule
